// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary to packed BCD plus a leading-zero blank mask.
// Latency IN_WIDTH+1 cycles from the start edge; start is ignored while busy (no queueing).
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(IN_WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    generate
        if (pow10(DIGITS) <= ((64'd1 << IN_WIDTH) - 64'd1)) begin : g_param_check
            $error("bin_to_bcd_seq: DIGITS too small to hold 2^IN_WIDTH-1");
        end
    endgenerate

    logic [1:0]                     state;
    logic [IN_WIDTH-1:0]            sr;
    logic [4*DIGITS-1:0]            scratch;
    logic [CW-1:0]                  cnt;

    logic [4*DIGITS-1:0]            adj;
    logic [4*DIGITS+IN_WIDTH-1:0]   shifted;
    logic [DIGITS-1:0]              mask;
    logic                           lead;

    // Add-3 correction is per nibble with no inter-digit carry, then one left shift.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
        shifted = {adj, sr} << 1;
    end

    // Digit k blanks only if it and every digit above it is zero; digit 0 never blanks.
    always_comb begin
        mask = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead    = lead && (scratch[4*k +: 4] == 4'd0);
            mask[k] = lead;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sr      <= '0;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            blank   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr      <= bin;
                        scratch <= '0;
                        cnt     <= CW'(IN_WIDTH);
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {scratch, sr} <= shifted;
                    cnt           <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= S_FINISH;
                end
                S_FINISH: begin
                    bcd   <= scratch;
                    blank <= mask;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a decimal reference model queues expectations, a monitor checks each done.
module tb_bin_to_bcd_seq;

    localparam int IN_WIDTH = 8;
    localparam int DIGITS   = 3;
    localparam int LAT      = IN_WIDTH + 2;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic [DIGITS-1:0]   blank;
        int                  done_cyc;
        int                  val;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [IN_WIDTH-1:0] bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    exp_t q[$];
    int   cyc;
    int   busy_run;
    int   checks;
    int   errors;

    bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input int v, input int dc);
        exp_t e;
        int   p;
        e.bcd      = '0;
        e.blank    = '0;
        e.done_cyc = dc;
        e.val      = v;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            e.bcd[4*k +: 4] = 4'((v / p) % 10);
            e.blank[k]      = (k >= 1) && (v < p);
            p = p * 10;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse and checks data, latency and busy width.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check($sformatf("bcd[%0d]", e.val), bcd, e.bcd);
                    check($sformatf("blank[%0d]", e.val), blank, e.blank);
                    check($sformatf("latency[%0d]", e.val), cyc, e.done_cyc);
                    check($sformatf("busy_cycles[%0d]", e.val), busy_run, LAT - 1);
                end
                busy_run = 0;
            end else if (q.size() > 0 && cyc > q[0].done_cyc) begin
                check($sformatf("timeout[%0d]", q[0].val), cyc, q[0].done_cyc);
                void'(q.pop_front());
            end
        end
    end

    // Issues one conversion and returns at the negedge of its done cycle.
    task automatic conv(input int v);
        start = 1'b1;
        bin   = IN_WIDTH'(v);
        q.push_back(model(v, cyc + LAT));
        @(negedge clk);
        start = 1'b0;
        bin   = IN_WIDTH'($urandom);
        repeat (LAT - 1) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        busy_run = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin      = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bcd", bcd, 0);
        check("rst_blank", blank, 0);
        rst_n = 1'b1;
        @(negedge clk);

        conv(0);
        @(negedge clk);
        conv(255);
        @(negedge clk);
        conv(7);
        conv(100);
        @(negedge clk);

        // A second start while busy must be ignored.
        start = 1'b1;
        bin   = 8'd42;
        q.push_back(model(42, cyc + LAT));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        bin   = 8'd99;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-conversion discards the result.
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_bcd", bcd, 0);
        check("midrst_blank", blank, 0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        conv(13);
        @(negedge clk);

        for (int v = 0; v < (1 << IN_WIDTH); v++) conv(v);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            conv(int'($urandom_range(0, (1 << IN_WIDTH) - 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (LAT + 2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
